// File: rtl/ex_stage_alu_mul.sv
// MIPS execute stage: operand forwarding, single-cycle ALU and an iterative shift-add multiplier.
// Optional HI register for MFHI is enabled by defining EX_MULHI_EN.
module ex_stage_alu_mul #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            alu_op_i,
  input  logic                  alu_src_i,
  input  logic                  reg_dst_i,
  input  logic [DATA_W-1:0]     rs_data_i,
  input  logic [DATA_W-1:0]     rt_data_i,
  input  logic [DATA_W-1:0]     imm_i,
  input  logic [REG_ADDR_W-1:0] rt_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic [1:0]            fwd_a_sel_i,
  input  logic [1:0]            fwd_b_sel_i,
  input  logic [DATA_W-1:0]     ex_mem_data_i,
  input  logic [DATA_W-1:0]     mem_wb_data_i,
  input  logic                  flush_i,
  output logic [DATA_W-1:0]     alu_result_o,
  output logic [DATA_W-1:0]     store_data_o,
  output logic [REG_ADDR_W-1:0] write_reg_o,
  output logic                  zero_o,
  output logic                  stall_o
);

  localparam int CNT_W = $clog2(DATA_W);
`ifdef EX_MULHI_EN
  localparam int PROD_W = 2 * DATA_W;
`else
  localparam int PROD_W = DATA_W;
`endif

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_MFHI = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  mcand, mplier;
  logic [PROD_W-1:0]  prod_acc, prod_sum;
  logic [DATA_W-1:0]  op_a, fwd_b, op_b, hi_val;
  logic               start, last_iter, step;

  always_comb begin
    case (fwd_a_sel_i)
      2'b01:   op_a = mem_wb_data_i;
      2'b10:   op_a = ex_mem_data_i;
      default: op_a = rs_data_i;
    endcase
    case (fwd_b_sel_i)
      2'b01:   fwd_b = mem_wb_data_i;
      2'b10:   fwd_b = ex_mem_data_i;
      default: fwd_b = rt_data_i;
    endcase
  end

  assign op_b         = alu_src_i ? imm_i : fwd_b;
  assign store_data_o = fwd_b;
  assign write_reg_o  = reg_dst_i ? rd_i : rt_i;

  assign start     = (state == IDLE) && (alu_op_i == OP_MUL) && !flush_i;
  assign last_iter = (cnt == CNT_W'(DATA_W - 1));
  assign step      = (state == BUSY) && !flush_i;
  assign prod_sum  = prod_acc + (mplier[0] ? (PROD_W'(mcand) << cnt) : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Flush drops the stall in the same cycle; reset masks it while asserted.
  always_comb begin
    state_next = state;
    stall_o    = 1'b0;
    case (state)
      IDLE: if (start) begin
        stall_o    = 1'b1;
        state_next = BUSY;
      end
      BUSY: if (flush_i) begin
        state_next = IDLE;
      end else begin
        stall_o = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (rst) stall_o = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      prod_acc <= '0;
    end else if (start) begin
      cnt      <= '0;
      mcand    <= op_a;
      mplier   <= op_b;
      prod_acc <= '0;
    end else if (step) begin
      cnt      <= cnt + 1'b1;
      mplier   <= mplier >> 1;
      prod_acc <= prod_sum;
    end
  end

`ifdef EX_MULHI_EN
  logic [DATA_W-1:0] hi_reg;

  // HI takes the upper half including the final partial product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   hi_reg <= '0;
    else if (step && last_iter) hi_reg <= prod_sum[PROD_W-1:DATA_W];
  end
  assign hi_val = hi_reg;
`else
  assign hi_val = '0;
`endif

  always_comb begin
    alu_result_o = '0;
    case (alu_op_i)
      OP_ADD:  alu_result_o = op_a + op_b;
      OP_SUB:  alu_result_o = op_a - op_b;
      OP_AND:  alu_result_o = op_a & op_b;
      OP_OR:   alu_result_o = op_a | op_b;
      OP_SLT:  alu_result_o = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_MUL:  alu_result_o = (state == DONE) ? prod_acc[DATA_W-1:0] : '0;
      OP_NOR:  alu_result_o = ~(op_a | op_b);
      OP_MFHI: alu_result_o = hi_val;
      default: alu_result_o = '0;
    endcase
  end

  assign zero_o = (alu_result_o == '0);

endmodule

// File: tb/tb_ex_stage_alu_mul.sv
// Directed self-checking bench for ex_stage_alu_mul: ALU vector table plus multiply/flush/reset sequences.
module tb_ex_stage_alu_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  alu_op_i;
  logic        alu_src_i, reg_dst_i;
  logic [31:0] rs_data_i, rt_data_i, imm_i;
  logic [4:0]  rt_i, rd_i;
  logic [1:0]  fwd_a_sel_i, fwd_b_sel_i;
  logic [31:0] ex_mem_data_i, mem_wb_data_i;
  logic        flush_i;
  logic [31:0] alu_result_o, store_data_o;
  logic [4:0]  write_reg_o;
  logic        zero_o, stall_o;

  int checks = 0;
  int errors = 0;

  ex_stage_alu_mul dut (
    .clk(clk), .rst(rst), .alu_op_i(alu_op_i), .alu_src_i(alu_src_i), .reg_dst_i(reg_dst_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i), .rt_i(rt_i), .rd_i(rd_i),
    .fwd_a_sel_i(fwd_a_sel_i), .fwd_b_sel_i(fwd_b_sel_i), .ex_mem_data_i(ex_mem_data_i),
    .mem_wb_data_i(mem_wb_data_i), .flush_i(flush_i), .alu_result_o(alu_result_o),
    .store_data_o(store_data_o), .write_reg_o(write_reg_o), .zero_o(zero_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        src;
    logic        dst;
    logic [31:0] rs, rt, imm;
    logic [4:0]  rt_idx, rd_idx;
    logic [1:0]  fa, fb;
    logic [31:0] exm, mwb;
    logic [31:0] exp_res, exp_store;
    logic [4:0]  exp_wr;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[13];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    alu_op_i      = v.op;
    alu_src_i     = v.src;
    reg_dst_i     = v.dst;
    rs_data_i     = v.rs;
    rt_data_i     = v.rt;
    imm_i         = v.imm;
    rt_i          = v.rt_idx;
    rd_i          = v.rd_idx;
    fwd_a_sel_i   = v.fa;
    fwd_b_sel_i   = v.fb;
    ex_mem_data_i = v.exm;
    mem_wb_data_i = v.mwb;
  endtask

  task automatic setRType(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_op_i    = op;
    alu_src_i   = 1'b0;
    reg_dst_i   = 1'b1;
    rs_data_i   = a;
    rt_data_i   = b;
    fwd_a_sel_i = 2'b00;
    fwd_b_sel_i = 2'b00;
  endtask

  // Runs a full multiply; operands are scrambled once busy to prove they were captured.
  task automatic doMul(input string name, input logic [31:0] a, input logic [31:0] b, input logic [31:0] expected);
    int n;
    setRType(3'b101, a, b);
    #1;
    n = 0;
    while (stall_o && n < 100) begin
      n++;
      @(posedge clk);
      #1;
      rs_data_i = 32'hDEAD_BEEF;
      rt_data_i = 32'h1234_5678;
    end
    checkOutput({name, "_stall_cycles"}, 32'(n), 32'd33);
    checkOutput({name, "_result"}, alu_result_o, expected);
  endtask

  initial begin
    vecs[0]  = '{3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd3, 5'd9, 2'b00, 2'b00, 32'd0, 32'd0, 32'd12, 32'd7, 5'd3, 1'b0};
    vecs[1]  = '{3'b001, 1'b0, 1'b1, 32'd1, 32'd2, 32'd0, 5'd3, 5'd9, 2'b10, 2'b01, 32'd100, 32'd3, 32'd97, 32'd3, 5'd9, 1'b0};
    vecs[2]  = '{3'b001, 1'b0, 1'b0, 32'd5, 32'd5, 32'd0, 5'd4, 5'd9, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd5, 5'd4, 1'b1};
    vecs[3]  = '{3'b001, 1'b0, 1'b0, 32'd0, 32'd1, 32'd0, 5'd4, 5'd9, 2'b00, 2'b00, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b0};
    vecs[4]  = '{3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd4, 5'd17, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd1, 5'd17, 1'b1};
    vecs[5]  = '{3'b010, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 5'd1, 5'd2, 2'b00, 2'b00, 32'd0, 32'd0, 32'h00F0_00F0, 32'h0FF0_0FF0, 5'd1, 1'b0};
    vecs[6]  = '{3'b011, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 5'd1, 5'd2, 2'b00, 2'b00, 32'd0, 32'd0, 32'hFFF0_FFF0, 32'h0FF0_0FF0, 5'd1, 1'b0};
    vecs[7]  = '{3'b110, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd1, 5'd2, 2'b00, 2'b00, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 5'd1, 1'b0};
    vecs[8]  = '{3'b100, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd1, 5'd2, 2'b00, 2'b00, 32'd0, 32'd0, 32'd1, 32'd1, 5'd1, 1'b0};
    vecs[9]  = '{3'b100, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd1, 5'd2, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 5'd1, 1'b1};
    vecs[10] = '{3'b000, 1'b1, 1'b0, 32'd10, 32'd99, 32'hFFFF_FFFC, 5'd6, 5'd2, 2'b00, 2'b00, 32'd0, 32'd0, 32'd6, 32'd99, 5'd6, 1'b0};
    vecs[11] = '{3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 5'd6, 5'd2, 2'b11, 2'b11, 32'd1000, 32'd2000, 32'd3, 32'd2, 5'd6, 1'b0};
    vecs[12] = '{3'b111, 1'b0, 1'b1, 32'd4, 32'd8, 32'd0, 5'd6, 5'd31, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd8, 5'd31, 1'b1};

    rst = 1'b1;
    flush_i = 1'b0;
    applyStimulus(vecs[0]);
    alu_op_i = 3'b101;
    #1;
    checkOutput("reset_stall_masked", 32'(stall_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_result", i), alu_result_o, vecs[i].exp_res);
      checkOutput($sformatf("vec%0d_store", i), store_data_o, vecs[i].exp_store);
      checkOutput($sformatf("vec%0d_wreg", i), 32'(write_reg_o), 32'(vecs[i].exp_wr));
      checkOutput($sformatf("vec%0d_zero", i), 32'(zero_o), 32'(vecs[i].exp_zero));
      checkOutput($sformatf("vec%0d_stall", i), 32'(stall_o), 32'd0);
      @(negedge clk);
    end

    doMul("mul6x7", 32'd6, 32'd7, 32'd42);
    checkOutput("mul6x7_zero", 32'(zero_o), 32'd0);
    @(posedge clk);
    #1;
    setRType(3'b000, 32'd1, 32'd1);
    #1;
    checkOutput("after_mul_stall", 32'(stall_o), 32'd0);
    checkOutput("after_mul_add", alu_result_o, 32'd2);

    doMul("mulmax", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
    @(posedge clk);
    #1;
    setRType(3'b111, 32'd0, 32'd0);
    #1;
    checkOutput("mfhi_stall", 32'(stall_o), 32'd0);
`ifdef EX_MULHI_EN
    checkOutput("mfhi_value", alu_result_o, 32'd1);
`else
    checkOutput("mfhi_value", alu_result_o, 32'd0);
`endif

    // Flush during BUSY cycle 10.
    setRType(3'b101, 32'd6, 32'd7);
    #1;
    checkOutput("flush_mul_start_stall", 32'(stall_o), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("flush_busy_stall", 32'(stall_o), 32'd1);
    flush_i = 1'b1;
    #1;
    checkOutput("flush_stall_drop", 32'(stall_o), 32'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    setRType(3'b000, 32'd5, 32'd7);
    #1;
    checkOutput("flush_idle_stall", 32'(stall_o), 32'd0);
    checkOutput("flush_next_add", alu_result_o, 32'd12);

    // Flush in IDLE blocks a MUL from starting.
    setRType(3'b101, 32'd2, 32'd2);
    flush_i = 1'b1;
    #1;
    checkOutput("flush_blocks_start", 32'(stall_o), 32'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    setRType(3'b001, 32'd9, 32'd4);
    #1;
    checkOutput("flush_blocked_idle", 32'(stall_o), 32'd0);
    checkOutput("flush_blocked_sub", alu_result_o, 32'd5);

    // Asynchronous reset in the middle of a multiply.
    setRType(3'b101, 32'd6, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("pre_reset_stall", 32'(stall_o), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("reset_stall_drop", 32'(stall_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    doMul("mul3x3", 32'd3, 32'd3, 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
